// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with freeze/flush/bubble control; optional FORWARDING_EN registers src indices.
// Latency: 1 cycle input to output. Backpressure: freeze holds all state; no handshake is exposed upstream.
// Priority at each edge: freeze > flush > bubble (hazard or failed condition) > normal load.
module id_ex_stage_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic        hazard,
    input  logic        cond_pass,
    input  logic [3:0]  exec_cmd_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        wb_en_in,
    input  logic        s_in,
    input  logic        b_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_rn_in,
    input  logic [31:0] val_rm_in,
    input  logic        imm_in,
    input  logic [11:0] shift_operand_in,
    input  logic [23:0] signed_imm_24_in,
    input  logic [3:0]  dest_in,
    input  logic        carry_in,
    input  logic [3:0]  src1_in,
    input  logic [3:0]  src2_in,
    output logic [3:0]  exec_cmd_out,
    output logic        mem_r_en_out,
    output logic        mem_w_en_out,
    output logic        wb_en_out,
    output logic        s_out,
    output logic        b_out,
    output logic [31:0] pc_out,
    output logic [31:0] val_rn_out,
    output logic [31:0] val_rm_out,
    output logic        imm_out,
    output logic [11:0] shift_operand_out,
    output logic [23:0] signed_imm_24_out,
    output logic [3:0]  dest_out,
    output logic        carry_out,
    output logic [3:0]  src1_out,
    output logic [3:0]  src2_out,
    output logic        valid_out
);

    typedef struct packed {
        logic [3:0] exec_cmd;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       wb_en;
        logic       s;
        logic       b;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        logic        carry;
    } data_t;

    ctrl_t ctrl_q, ctrl_d, ctrl_in;
    data_t data_q, data_d, data_in;
    logic  valid_q, valid_d;
    logic  bubble;

    assign ctrl_in = '{exec_cmd: exec_cmd_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in,
                       wb_en: wb_en_in, s: s_in, b: b_in};
    assign data_in = '{pc: pc_in, val_rn: val_rn_in, val_rm: val_rm_in, imm: imm_in,
                       shift_operand: shift_operand_in, signed_imm_24: signed_imm_24_in,
                       dest: dest_in, carry: carry_in};

    // A killed instruction is treated exactly like a hazard bubble: operands move, controls do not.
    assign bubble = hazard | ~cond_pass;

    always_comb begin
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (freeze) begin
            ctrl_d  = ctrl_q;
        end else if (flush) begin
            ctrl_d  = '0;
            data_d  = '0;
            valid_d = 1'b0;
        end else if (bubble) begin
            ctrl_d  = '0;
            data_d  = data_in;
            valid_d = 1'b0;
        end else begin
            ctrl_d  = ctrl_in;
            data_d  = data_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign exec_cmd_out      = ctrl_q.exec_cmd;
    assign mem_r_en_out      = ctrl_q.mem_r_en;
    assign mem_w_en_out      = ctrl_q.mem_w_en;
    assign wb_en_out         = ctrl_q.wb_en;
    assign s_out             = ctrl_q.s;
    assign b_out             = ctrl_q.b;
    assign pc_out            = data_q.pc;
    assign val_rn_out        = data_q.val_rn;
    assign val_rm_out        = data_q.val_rm;
    assign imm_out           = data_q.imm;
    assign shift_operand_out = data_q.shift_operand;
    assign signed_imm_24_out = data_q.signed_imm_24;
    assign dest_out          = data_q.dest;
    assign carry_out         = data_q.carry;
    assign valid_out         = valid_q;

`ifdef FORWARDING_EN
    logic [3:0] src1_q, src2_q;

    // Source indices follow the data-field rules: a bubble still loads them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src1_q <= 4'h0;
            src2_q <= 4'h0;
        end else if (!freeze) begin
            if (flush) begin
                src1_q <= 4'h0;
                src2_q <= 4'h0;
            end else begin
                src1_q <= src1_in;
                src2_q <= src2_in;
            end
        end
    end

    assign src1_out = src1_q;
    assign src2_out = src2_q;
`else
    logic unused_src;
    assign unused_src = ^{src1_in, src2_in};
    assign src1_out   = 4'h0;
    assign src2_out   = 4'h0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized and directed bench for id_ex_stage_reg against a field-level reference model.
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, flush, hazard, cond_pass;
    logic [3:0]  exec_cmd_in;
    logic        mem_r_en_in, mem_w_en_in, wb_en_in, s_in, b_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic        imm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in;
    logic        carry_in;
    logic [3:0]  src1_in, src2_in;

    logic [3:0]  exec_cmd_out;
    logic        mem_r_en_out, mem_w_en_out, wb_en_out, s_out, b_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic        imm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic [3:0]  dest_out;
    logic        carry_out;
    logic [3:0]  src1_out, src2_out;
    logic        valid_out;

    int checks = 0;
    int errors = 0;

    // Layout: {ctrl[155:147], pc, rn, rm, imm, shift, simm, dest, carry, src1[8:5], src2[4:1], valid[0]}
    logic [155:0] exp_v;
    logic [155:0] held;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard), .cond_pass(cond_pass),
        .exec_cmd_in(exec_cmd_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .wb_en_in(wb_en_in), .s_in(s_in), .b_in(b_in),
        .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .imm_in(imm_in), .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .dest_in(dest_in), .carry_in(carry_in), .src1_in(src1_in), .src2_in(src2_in),
        .exec_cmd_out(exec_cmd_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .wb_en_out(wb_en_out), .s_out(s_out), .b_out(b_out),
        .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .imm_out(imm_out), .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
        .dest_out(dest_out), .carry_out(carry_out), .src1_out(src1_out), .src2_out(src2_out),
        .valid_out(valid_out)
    );

    function automatic logic [155:0] out_vec();
        return {exec_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out, s_out, b_out,
                pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm_24_out,
                dest_out, carry_out, src1_out, src2_out, valid_out};
    endfunction

    function automatic logic [155:0] in_vec();
        return {exec_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in, s_in, b_in,
                pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm_24_in,
                dest_in, carry_in, src1_in, src2_in, 1'b1};
    endfunction

    // What the EX slot should hold after one edge, given the inputs seen at that edge.
    task automatic model_edge();
        logic [155:0] nv;
        if (!rst) begin
            exp_v = '0;
        end else if (freeze) begin
            exp_v = exp_v;
        end else if (flush) begin
            exp_v = '0;
        end else begin
            nv = in_vec();
            if (hazard || !cond_pass) begin
                nv[155:147] = '0;
                nv[0]       = 1'b0;
            end
            exp_v = nv;
        end
`ifndef FORWARDING_EN
        exp_v[8:1] = '0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        freeze = 0; flush = 0; hazard = 0; cond_pass = 1;
        exec_cmd_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0; s_in = 0; b_in = 0;
        pc_in = 0; val_rn_in = 0; val_rm_in = 0; imm_in = 0; shift_operand_in = 0;
        signed_imm_24_in = 0; dest_in = 0; carry_in = 0; src1_in = 0; src2_in = 0;
    endtask

    task automatic random_data();
        exec_cmd_in = 4'($urandom_range(15));
        mem_r_en_in = 1'($urandom_range(1)); mem_w_en_in = 1'($urandom_range(1));
        wb_en_in = 1'($urandom_range(1)); s_in = 1'($urandom_range(1)); b_in = 1'($urandom_range(1));
        pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
        imm_in = 1'($urandom_range(1)); shift_operand_in = 12'($urandom);
        signed_imm_24_in = 24'($urandom); dest_in = 4'($urandom_range(15));
        carry_in = 1'($urandom_range(1));
        src1_in = 4'($urandom_range(15)); src2_in = 4'($urandom_range(15));
    endtask

    task automatic test_reset();
        rst = 0;
        clear_inputs();
        exp_v = '0;
        #2;
        checks++;
        if (out_vec() !== 156'd0) begin
            errors++; $display("FAIL reset_state: got %h expected 0", out_vec());
        end
        #5 rst = 1;
        exec_cmd_in = 4'hA; mem_r_en_in = 1; mem_w_en_in = 1; wb_en_in = 1; s_in = 1; b_in = 1;
        pc_in = 32'hDEAD_BEEF; val_rn_in = 32'h1234_5678; val_rm_in = 32'h8765_4321; imm_in = 1;
        shift_operand_in = 12'hABC; signed_imm_24_in = 24'h55AA55; dest_in = 4'hF; carry_in = 1;
        src1_in = 4'h6; src2_in = 4'h5;
        tick();
        checks++;
        if (out_vec() !== exp_v || valid_out !== 1'b1) begin
            errors++; $display("FAIL first_load: got %h expected %h", out_vec(), exp_v);
        end
        #3 rst = 0;
        exp_v = '0;
        #1;
        checks++;
        if (out_vec() !== 156'd0) begin
            errors++; $display("FAIL async_reset: got %h expected 0", out_vec());
        end
        tick();
        checks++;
        if (out_vec() !== 156'd0) begin
            errors++; $display("FAIL reset_held: got %h expected 0", out_vec());
        end
        #2 rst = 1;
        tick();
        checks++;
        if (out_vec() !== exp_v || valid_out !== 1'b1) begin
            errors++; $display("FAIL load_after_reset: got %h expected %h", out_vec(), exp_v);
        end
    endtask

    task automatic test_load();
        clear_inputs();
        exec_cmd_in = 4'b0010; wb_en_in = 1; pc_in = 32'h10; val_rn_in = 5; dest_in = 3;
        tick();
        checks++;
        if (exec_cmd_out !== 4'b0010 || wb_en_out !== 1'b1 || pc_out !== 32'h10 ||
            val_rn_out !== 32'd5 || dest_out !== 4'd3 || valid_out !== 1'b1) begin
            errors++; $display("FAIL normal_load: cmd %h wb %b pc %h rn %h dest %h valid %b expected 2 1 10 5 3 1",
                                exec_cmd_out, wb_en_out, pc_out, val_rn_out, dest_out, valid_out);
        end
        checks++;
        if (out_vec() !== exp_v) begin
            errors++; $display("FAIL normal_load_all: got %h expected %h", out_vec(), exp_v);
        end
    endtask

    task automatic test_kill();
        clear_inputs();
        exec_cmd_in = 4'b0010; wb_en_in = 1; mem_w_en_in = 1; s_in = 1; b_in = 1;
        pc_in = 32'h10; val_rn_in = 5; dest_in = 3; cond_pass = 0;
        tick();
        checks++;
        if (exec_cmd_out !== 4'b0 || wb_en_out !== 1'b0 || mem_w_en_out !== 1'b0 || s_out !== 1'b0 ||
            b_out !== 1'b0 || valid_out !== 1'b0 || pc_out !== 32'h10 || val_rn_out !== 32'd5) begin
            errors++; $display("FAIL kill: cmd %h wb %b mw %b s %b b %b valid %b pc %h rn %h expected 0 0 0 0 0 0 10 5",
                                exec_cmd_out, wb_en_out, mem_w_en_out, s_out, b_out, valid_out, pc_out, val_rn_out);
        end
    endtask

    task automatic test_freeze_flush();
        clear_inputs();
        random_data();
        tick();
        held = exp_v;
        for (int i = 0; i < 3; i++) begin
            freeze = 1; flush = 1;
            random_data();
            hazard = 1'($urandom_range(1));
            tick();
            checks++;
            if (out_vec() !== held) begin
                errors++; $display("FAIL freeze_hold_%0d: got %h expected %h", i, out_vec(), held);
            end
        end
        freeze = 0;
        tick();
        checks++;
        if (out_vec() !== 156'd0) begin
            errors++; $display("FAIL flush_after_freeze: got %h expected 0", out_vec());
        end
        random_data();
        tick();
        checks++;
        if (out_vec() !== 156'd0) begin
            errors++; $display("FAIL flush_held: got %h expected 0", out_vec());
        end
    endtask

    task automatic test_hazard();
        clear_inputs();
        exec_cmd_in = 4'b0100; mem_w_en_in = 1; pc_in = 32'h44; hazard = 1;
        tick();
        checks++;
        if (mem_w_en_out !== 1'b0 || exec_cmd_out !== 4'b0 || valid_out !== 1'b0 || pc_out !== 32'h44) begin
            errors++; $display("FAIL hazard_bubble: mw %b cmd %h valid %b pc %h expected 0 0 0 44",
                                mem_w_en_out, exec_cmd_out, valid_out, pc_out);
        end
        hazard = 0;
        tick();
        checks++;
        if (mem_w_en_out !== 1'b1 || exec_cmd_out !== 4'b0100 || valid_out !== 1'b1) begin
            errors++; $display("FAIL hazard_release: mw %b cmd %h valid %b expected 1 4 1",
                                mem_w_en_out, exec_cmd_out, valid_out);
        end
    endtask

    task automatic test_forwarding();
        logic [3:0] e1, e2;
`ifdef FORWARDING_EN
        e1 = 4'd7; e2 = 4'd9;
`else
        e1 = 4'd0; e2 = 4'd0;
`endif
        clear_inputs();
        src1_in = 7; src2_in = 9;
        tick();
        checks++;
        if (src1_out !== e1 || src2_out !== e2) begin
            errors++; $display("FAIL forwarding: src1 %0d src2 %0d expected %0d %0d", src1_out, src2_out, e1, e2);
        end
    endtask

    task automatic test_reset_override();
        clear_inputs();
        random_data();
        tick();
        freeze = 1; flush = 1;
        tick();
        #2 rst = 0;
        exp_v = '0;
        #1;
        checks++;
        if (out_vec() !== 156'd0) begin
            errors++; $display("FAIL reset_over_freeze: got %h expected 0", out_vec());
        end
        #2 rst = 1;
        freeze = 0; flush = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            random_data();
            freeze    = ($urandom_range(3) == 0);
            flush     = ($urandom_range(5) == 0);
            hazard    = ($urandom_range(4) == 0);
            cond_pass = ($urandom_range(4) != 0);
            tick();
            checks++;
            if (out_vec() !== exp_v) begin
                errors++; $display("FAIL random_%0d: got %h expected %h", i, out_vec(), exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_kill();
        test_freeze_flush();
        test_hazard();
        test_forwarding();
        test_reset_override();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single rising-edge clock.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port freeze, input, 1 bit: global stall (memory wait); hold all state.
REQ-004 The block SHALL have the port flush, input, 1 bit: branch taken in EX; load bubble.
REQ-005 The block SHALL have the port hazard, input, 1 bit: data hazard from hazard unit; load bubble controls.
REQ-006 The block SHALL have the port cond_pass, input, 1 bit: result of the condition check for the ID instruction.
REQ-007 The block SHALL have the ports exec_cmd_in (input, 4 bits), mem_r_en_in, mem_w_en_in, wb_en_in, s_in and b_in (input, 1 bit each): control-unit decode.
REQ-008 The block SHALL have the ports pc_in (input, 32 bits), val_rn_in (input, 32 bits) and val_rm_in (input, 32 bits): instruction PC and register operands.
REQ-009 The block SHALL have the ports imm_in (input, 1 bit), shift_operand_in (input, 12 bits), signed_imm_24_in (input, 24 bits), dest_in (input, 4 bits) and carry_in (input, 1 bit): operand fields and status-register C.
REQ-010 The block SHALL have the ports src1_in and src2_in (input, 4 bits each): source register indices, used only when FORWARDING_EN is defined.
REQ-011 The block SHALL have one registered output per input of REQ-007 to REQ-010, named with the _out suffix, of the same width.
REQ-012 The block SHALL have the port valid_out, output, 1 bit: the EX-stage slot holds a live instruction.

Function
REQ-013 All outputs SHALL update only on the rising edge of clk; input-to-output latency SHALL be 1 cycle.
REQ-014 Edge priority SHALL be: freeze, then flush, then bubble (hazard=1 or cond_pass=0), then normal load.
REQ-015 freeze=1 SHALL hold every output unchanged, regardless of flush, hazard or cond_pass.
REQ-016 flush=1 with freeze=0 SHALL clear every output to 0, including data fields and valid_out.
REQ-017 A bubble SHALL clear exec_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out, s_out, b_out and valid_out to 0, and SHALL still load the data and field outputs from the inputs.
REQ-018 A normal load SHALL copy every input to its output and SHALL set valid_out=1.
REQ-019 A killed instruction (cond_pass=0) SHALL never assert mem_w_en_out, wb_en_out, s_out or b_out.
REQ-020 exec_cmd_out SHALL be 4'b0000 (NOP) whenever valid_out=0.
REQ-021 When freeze deasserts, the next edge SHALL be evaluated against the inputs present at that edge; no stale request SHALL be replayed.
REQ-022 A flush held over N edges SHALL produce N bubbles; flush asserted during freeze SHALL take effect on the first edge after freeze drops, if still asserted then.

Reset
REQ-023 rst=0 SHALL asynchronously clear every output to 0, independent of clk.
REQ-024 Reset deassertion SHALL be sampled synchronously; the first load SHALL occur on the first clk edge with rst=1.
REQ-025 Reset asserted mid-freeze or mid-flush SHALL override both.

Configuration
REQ-026 When FORWARDING_EN is defined, src1_out and src2_out SHALL be registered with the same freeze/flush/bubble rules as the data fields (flush clears them; a bubble loads them).
REQ-027 When FORWARDING_EN is not defined, src1_out and src2_out SHALL be constant 4'h0 and SHALL contain no flops.

Verification
REQ-028 The bench SHALL cover reset: rst=0 mid-cycle with all inputs nonzero -> all outputs 0 immediately, before any clk edge.
REQ-029 The bench SHALL cover a normal load: exec_cmd_in=4'b0010, wb_en_in=1, pc_in=32'h10, val_rn_in=5, dest_in=3, cond_pass=1 -> next edge: identical values on the outputs, valid_out=1.
REQ-030 The bench SHALL cover a kill: same stimulus as REQ-029 with cond_pass=0 -> controls 0, valid_out=0, pc_out=32'h10, val_rn_out=5.
REQ-031 The bench SHALL cover freeze priority: freeze=1 and flush=1 for 3 edges after a load -> outputs unchanged; freeze=0 with flush=1 -> all outputs 0.
REQ-032 The bench SHALL cover a hazard: hazard=1 with mem_w_en_in=1 -> mem_w_en_out=0, exec_cmd_out=0; hazard=0 on the next edge -> mem_w_en_out=1.
REQ-033 The bench SHALL cover forwarding: src1_in=7, src2_in=9 with FORWARDING_EN defined -> src1_out=7, src2_out=9; without FORWARDING_EN -> both 0.
